// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode sequencer for the digital clock.
// Emits field strobes with auto-repeat, inactivity timeout and blink.
module clock_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter int unsigned TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       tick_1hz,
    output logic       run_en,
    output logic [1:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_sec,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam int TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
    localparam logic [24:0] RPT_TOP = 25'(REPEAT_DELAY);
    localparam logic [24:0] RPT_RLD = 25'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [TW-1:0] TO_TOP = TW'(TIMEOUT_S);

    state_t        state_q, state_d;
    logic          prev_mode_q, prev_up_q, prev_down_q;
    logic [24:0]   rpt_q, rpt_d, rpt_inc;
    logic [TW-1:0] idle_q, idle_d, idle_inc;
    logic          blink_q, blink_d;
    logic          run_en_q;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          clr_q, clr_d;

    logic mode_edge, up_edge, dn_edge, any_edge;
    logic one_held, in_set, timeout, rpt_hit;

    assign mode_edge = btn_mode & ~prev_mode_q;
    assign up_edge   = btn_up & ~prev_up_q;
    assign dn_edge   = btn_down & ~prev_down_q;
    assign any_edge  = mode_edge | up_edge | dn_edge;
    assign one_held  = btn_up ^ btn_down;
    assign in_set    = (state_q != RUN);
    assign rpt_inc   = rpt_q + 25'd1;
    assign idle_inc  = idle_q + TW'(1);
    assign timeout   = in_set & tick_1hz & ~any_edge
                     & (idle_inc == TO_TOP);
    assign rpt_hit   = (rpt_inc == RPT_TOP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next state: mode edge advances, timeout falls back to RUN
    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            state_d = state_t'(state_q + 2'd1);
        end else if (timeout) begin
            state_d = RUN;
        end
    end

    // Strobe, repeat, inactivity and blink next values
    always_comb begin
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        clr_d   = 1'b0;
        rpt_d   = 25'd0;
        idle_d  = idle_q;
        blink_d = blink_q;
        case (state_q)
            SET_HOUR, SET_MIN: begin
                if (mode_edge || !one_held) begin
                    rpt_d = 25'd0;
                end else if (up_edge || dn_edge) begin
                    inc_d = up_edge;
                    dec_d = dn_edge;
                end else if (rpt_hit) begin
                    rpt_d = RPT_RLD;
                    inc_d = btn_up;
                    dec_d = btn_down;
                end else begin
                    rpt_d = rpt_inc;
                end
            end
            SET_SEC: begin
                clr_d = ~mode_edge & one_held & (up_edge | dn_edge);
            end
            default: begin
                rpt_d = 25'd0;
            end
        endcase
        if (state_d == RUN || any_edge) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_inc;
        end
        if (state_d == RUN) begin
            blink_d = 1'b0;
        end else if (state_d == SET_HOUR && state_q != SET_HOUR) begin
            blink_d = 1'b0;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    // Registered outputs, counters and button history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_mode_q <= 1'b1;
            prev_up_q   <= 1'b1;
            prev_down_q <= 1'b1;
            rpt_q       <= 25'd0;
            idle_q      <= '0;
            blink_q     <= 1'b0;
            run_en_q    <= 1'b1;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            clr_q       <= 1'b0;
        end else if (ena) begin
            prev_mode_q <= btn_mode;
            prev_up_q   <= btn_up;
            prev_down_q <= btn_down;
            rpt_q       <= rpt_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            run_en_q    <= (state_d == RUN);
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            clr_q       <= clr_d;
        end else begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            clr_q <= 1'b0;
        end
    end

    assign run_en    = run_en_q;
    assign field_sel = state_q;
    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign clr_sec   = clr_q;
    assign blink     = blink_q;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock top. Takes three debounced push-button levels plus the 1 Hz tick from the timebase. Sequences the clock through run and set modes, and drives one-cycle increment/decrement/clear strobes to the selected hours, minutes or seconds counter. It also gates the timekeeping counters and produces the display blink flag.

## Interface
- REPEAT_DELAY, 25000000: cycles a held up/down button must stay held before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_RATE, 10000000: cycles between auto-repeat strobes once repeating (0.2 s at 50 MHz).
- TIMEOUT_S, 10: number of tick_1hz pulses with no button activity after which set mode is abandoned.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  design enable; when 0, all state holds and every strobe output is 0.
- btn_mode  in  1  debounced mode button, level, active high.
- btn_up  in  1  debounced up button, level, active high.
- btn_down  in  1  debounced down button, level, active high.
- tick_1hz  in  1  one-cycle pulse from timebase, once per second.
- run_en  out  1  1 = timekeeping counters advance.
- field_sel  out  2  0 none, 1 hours, 2 minutes, 3 seconds.
- inc_pulse  out  1  one-cycle increment strobe to the selected field.
- dec_pulse  out  1  one-cycle decrement strobe to the selected field.
- clr_sec  out  1  one-cycle strobe zeroing the seconds counter.
- blink  out  1  display blank phase for the selected field.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC. field_sel encodes the state: 0/1/2/3.
- Edge detection: each button has a previous-sample register. An edge means current = 1 and previous = 0.
- Previous-sample registers reset to 1, so a button held through reset release produces no edge.
- btn_mode edge advances state: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN.
- RUN:
  - run_en = 1; blink = 0.
  - up/down are ignored and the repeat counter is held at 0.
- SET_HOUR / SET_MIN:
  - run_en = 0.
  - An up edge gives inc_pulse; a down edge gives dec_pulse.
  - Wrap-around is the responsibility of the field counter, not this block.
- SET_SEC:
  - run_en = 0.
  - An up or down edge gives clr_sec only. inc_pulse and dec_pulse stay 0. There is no auto-repeat.
- Auto-repeat (SET_HOUR/SET_MIN only):
  - A 25-bit counter clears on each edge and counts while exactly one of up/down stays held.
  - When the count reaches REPEAT_DELAY, emit one strobe and reload the counter to REPEAT_DELAY-REPEAT_RATE.
  - Strobes then repeat every REPEAT_RATE cycles.
- Both up and down high: no strobes; the repeat counter clears. Releasing one does not create an edge on the other.
- A mode edge in the same cycle as an up/down edge: mode wins and the up/down edge is discarded.
- Timeout:
  - An inactivity counter clears on any button edge and on entering a set state.
  - In set states it increments on tick_1hz. On reaching TIMEOUT_S the state returns to RUN.
  - A button edge in the same cycle as the terminal tick wins: the counter clears and the state is kept.
- blink: toggles on each tick_1hz while in a set state; forced to 0 on entering RUN and on entering SET_HOUR.
- Reset is legal mid-setting and returns everything to reset values. Counters already strobed keep their values.

## Timing
- Reset values:
  - state RUN, run_en 1, field_sel 0.
  - inc_pulse, dec_pulse, clr_sec, blink all 0.
  - Repeat and inactivity counters 0.
- All outputs are registered.
- A button first sampled high at edge k (previous sample low) gives a strobe high for the cycle after edge k, for exactly one cycle.
- A mode edge sampled at edge k gives new field_sel/run_en after edge k.
- The first auto-repeat strobe comes REPEAT_DELAY cycles after the edge strobe.
- ena = 0 freezes all registers, including the previous-sample registers. An edge that arrives while ena = 0 is detected once ena returns.

## Test plan
All scenarios use REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT_S=3.
- Reset: hold rst_n = 0 for 5 cycles with btn_up = 1 → run_en = 1, field_sel = 0, all strobes 0; no inc_pulse after release.
- Mode cycling: four btn_mode presses, each 3 cycles → field_sel goes 1, 2, 3, 0; run_en is 0, 0, 0, 1.
- Auto-repeat: in SET_HOUR hold btn_up for 20 cycles → inc_pulse at cycles 1, 9, 13, 17 after the rising edge; no dec_pulse.
- Seconds clear: in SET_SEC pulse btn_down once → exactly one clr_sec; inc_pulse and dec_pulse stay 0.
- Timeout: in SET_MIN apply 3 tick_1hz with no buttons → state RUN, field_sel = 0, run_en = 1, blink = 0. Repeat with a btn_up edge on the 3rd tick → state stays SET_MIN.
- Conflicts:
  - btn_mode and btn_up rise in the same cycle while in SET_HOUR → field_sel = 2, no inc_pulse.
  - Up and down both held → no strobes.
